// File: rtl/swervolf_sevenseg.sv
// Wishbone-mapped 8-digit seven-segment controller: hex or raw patterns scanned onto
// active-low anode/cathode outputs with a blanking gap between digits.
module swervolf_sevenseg #(
  parameter int unsigned DIGIT_CYCLES = 6250,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [7:0]  o_anode,
  output logic [7:0]  o_cathode
);

  localparam int unsigned CntMax = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_CYCLES - 1);

  typedef enum logic [0:0] {StBlank, StLit} state_e;

  logic [31:0] data_q, raw_lo_q, raw_hi_q;
  logic [16:0] ctrl_q;
  logic        ack_q;
  logic [31:0] rdt_q;
  logic        bus_req;
  logic [31:0] reg_rd, wr_merged;
  logic [1:0]  unused_adr;

  assign unused_adr = i_wb_adr[1:0];
  assign bus_req    = i_wb_cyc & i_wb_stb & ~ack_q;

  always_comb begin
    reg_rd = '0;
    unique case (i_wb_adr[3:2])
      2'd0: reg_rd = data_q;
      2'd1: reg_rd = {15'd0, ctrl_q};
      2'd2: reg_rd = raw_lo_q;
      2'd3: reg_rd = raw_hi_q;
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    wr_merged = reg_rd;
    for (int b = 0; b < 4; b++) begin
      if (i_wb_sel[b]) wr_merged[8*b +: 8] = i_wb_dat[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      raw_lo_q <= '0;
      raw_hi_q <= '0;
    end else begin
      ack_q <= bus_req;
      rdt_q <= bus_req ? reg_rd : '0;
      if (bus_req && i_wb_we) begin
        unique case (i_wb_adr[3:2])
          2'd0: data_q   <= wr_merged;
          2'd1: ctrl_q   <= wr_merged[16:0];
          2'd2: raw_lo_q <= wr_merged;
          2'd3: raw_hi_q <= wr_merged;
          default: ;
        endcase
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      anode_q, anode_d, cathode_q, cathode_d;
  logic [7:0]      en_mask, dp_mask, cur_pat;
  logic [63:0]     raw_all;

  assign en_mask = ctrl_q[7:0];
  assign dp_mask = ctrl_q[15:8];
  assign raw_all = {raw_hi_q, raw_lo_q};

  always_comb begin
    if (ctrl_q[16]) cur_pat = raw_all[{idx_q, 3'b000} +: 8];
    else            cur_pat = {dp_mask[idx_q], hex7(data_q[{idx_q, 2'b00} +: 4])};
  end

  // cathode_q doubles as the pattern latch, so bus writes never tear a lit digit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CntW'(1);
    anode_d   = anode_q;
    cathode_d = cathode_q;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d   = StLit;
          cnt_d     = '0;
          anode_d   = en_mask[idx_q] ? ~(8'd1 << idx_q) : 8'hFF;
          cathode_d = ~cur_pat;
        end
      end
      StLit: begin
        if (cnt_q == DigitLast) begin
          state_d   = StBlank;
          cnt_d     = '0;
          idx_d     = idx_q + 3'd1;
          anode_d   = 8'hFF;
          cathode_d = 8'hFF;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StBlank;
      idx_q     <= '0;
      cnt_q     <= '0;
      anode_q   <= 8'hFF;
      cathode_q <= 8'hFF;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign o_anode   = anode_q;
  assign o_cathode = cathode_q;

endmodule

// File: tb/tb_swervolf_sevenseg.sv
// Randomised bench for swervolf_sevenseg: a time-based display model and a register model
// predict anode/cathode and bus read data.
module tb_swervolf_sevenseg;

  localparam int D = 8;
  localparam int B = 2;
  localparam int P = D + B;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [7:0] SCAN_CA [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  anode, cathode;

  swervolf_sevenseg #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rstn(rstn),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .o_anode(anode), .o_cathode(cathode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Register model (updated by the bench after each acked write) and display model.
  logic [31:0] m_regs [4];
  int          k, m, m_digit;
  logic        m_lit;
  logic [7:0]  exp_an = 8'hFF, exp_ca = 8'hFF, pat;
  logic [63:0] raw;

  initial for (int i = 0; i < 4; i++) m_regs[i] = '0;

  always @(posedge clk) begin
    if (!rstn) begin
      k = 0; m_lit = 1'b0; m_digit = 0;
      exp_an = 8'hFF; exp_ca = 8'hFF;
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
    end else begin
      k++;
      m = k - B;
      if (m >= 0 && m % P == 0) begin
        m_digit = (m / P) % 8;
        raw = {m_regs[3], m_regs[2]};
        if (m_regs[1][16]) pat = raw[8*m_digit +: 8];
        else pat = {m_regs[1][8+m_digit], HEX[m_regs[0][4*m_digit +: 4]]};
        exp_ca = ~pat;
        exp_an = m_regs[1][m_digit] ? ~(8'd1 << m_digit) : 8'hFF;
        m_lit = 1'b1;
      end else if (m >= 0 && m % P == D) begin
        m_lit = 1'b0; exp_an = 8'hFF; exp_ca = 8'hFF;
      end
    end
  end

  task automatic wb(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic w, output logic [31:0] rd);
    int waited;
    logic [31:0] merged;
    @(negedge clk);
    wb_adr = a; wb_dat = d; wb_sel = s; wb_we = w; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    waited = 1;
    while (!wb_ack && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    rd = wb_rdt;
    n_tests++;
    if (wb_ack !== 1'b1 || waited != 1) begin
      n_fail++;
      $display("FAIL wb_ack_latency adr=%h got ack=%b after %0d cycles, want ack=1 after 1",
               a, wb_ack, waited);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (w) begin
      merged = m_regs[a[3:2]];
      for (int b = 0; b < 4; b++) if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
      if (a[3:2] == 2'd1) merged = merged & 32'h0001FFFF;
      m_regs[a[3:2]] = merged;
    end
    @(negedge clk);
    n_tests++;
    if (wb_ack !== 1'b0 || wb_rdt !== 32'd0) begin
      n_fail++;
      $display("FAIL wb_idle got ack=%b rdt=%h, want ack=0 rdt=0", wb_ack, wb_rdt);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] junk;
    wb(a, d, s, 1'b1, junk);
  endtask

  task automatic rd_check(input logic [3:0] a);
    logic [31:0] got, want;
    want = m_regs[a[3:2]];
    wb(a, 32'hDEADBEEF, 4'hF, 1'b0, got);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL read adr=%h got %h want %h", a, got, want);
    end
  endtask

  task automatic run_check(input int n);
    repeat (n) begin
      @(negedge clk);
      n_tests++;
      if (anode !== exp_an || cathode !== exp_ca) begin
        n_fail++;
        $display("FAIL scan t=%0t got an=%h ca=%h want an=%h ca=%h", $time, anode, cathode,
                 exp_an, exp_ca);
      end
    end
  endtask

  // Scans with checking until the model has digit d freshly lit; timeout is a failure.
  task automatic wait_lit(input int d);
    int cyc;
    cyc = 0;
    while (!(m_lit && m_digit == d && (k - B) % P == 0) && cyc < 200) begin
      run_check(1);
      cyc++;
    end
    if (cyc >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL wait_lit digit %0d not reached within 200 cycles", d);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (anode !== 8'hFF || cathode !== 8'hFF || wb_ack !== 1'b0 || wb_rdt !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold got an=%h ca=%h ack=%b rdt=%h, want FF FF 0 0",
                 anode, cathode, wb_ack, wb_rdt);
      end
    end
    rstn = 1'b1;
    run_check(30);
    rd_check(4'h4);
    rd_check(4'h0);
  endtask

  task automatic test_hex_scan();
    wr(4'h0, 32'h12345678, 4'hF);
    wr(4'h4, 32'h000000FF, 4'hF);
    for (int d = 0; d < 8; d++) begin
      wait_lit(d);
      n_tests++;
      if (anode !== ~(8'd1 << d) || cathode !== SCAN_CA[d]) begin
        n_fail++;
        $display("FAIL hex_digit%0d got an=%h ca=%h want an=%h ca=%h", d, anode, cathode,
                 ~(8'd1 << d), SCAN_CA[d]);
      end
    end
    run_check(20);
  endtask

  task automatic test_byte_lanes();
    wr(4'h4, 32'h0000FFFF, 4'hF);
    wr(4'h0, 32'h00AA0000, 4'b0100);
    rd_check(4'h0);
    for (int d = 4; d < 6; d++) begin
      wait_lit(d);
      n_tests++;
      if (cathode !== 8'h08) begin
        n_fail++;
        $display("FAIL dp_digit%0d got ca=%h want 08", d, cathode);
      end
    end
    run_check(P * 8);
  endtask

  task automatic test_raw();
    wr(4'h8, 32'h000000FF, 4'hF);
    wr(4'hC, 32'h00000000, 4'hF);
    wr(4'h4, 32'h000100FF, 4'hF);
    wait_lit(0);
    n_tests++;
    if (cathode !== 8'h00) begin
      n_fail++;
      $display("FAIL raw_digit0 got ca=%h want 00", cathode);
    end
    run_check(P * 8);
  endtask

  task automatic test_mid_update();
    wr(4'h4, 32'h000000FF, 4'hF);
    wr(4'h0, 32'h12345678, 4'hF);
    wait_lit(2);
    wr(4'h0, 32'h00000000, 4'hF);
    n_tests++;
    if (cathode !== 8'h82) begin
      n_fail++;
      $display("FAIL mid_update_hold got ca=%h want 82", cathode);
    end
    wait_lit(3);
    n_tests++;
    if (cathode !== 8'hC0) begin
      n_fail++;
      $display("FAIL mid_update_next got ca=%h want C0", cathode);
    end
    run_check(30);
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [3:0] a;
      a = 4'({$urandom_range(0, 3), 2'b00});
      wr(a, $urandom, 4'($urandom_range(1, 15)));
      rd_check(4'({$urandom_range(0, 3), 2'b00}));
      run_check($urandom_range(5, 40));
    end
  endtask

  task automatic test_reset_mid();
    wr(4'h4, 32'h000000FF, 4'hF);
    wait_lit(5);
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (anode !== 8'hFF || cathode !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_mid got an=%h ca=%h want FF FF", anode, cathode);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_check(P * 8 + 5);
    rd_check(4'h4);
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_byte_lanes();
    test_raw();
    test_mid_update();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
